// File: rtl/serving_host_loader_if.sv
// Host byte-stream, Wishbone bridge and memory-mux signals of the host loader,
// bundled so the loader and its environment share one connection.
// The master modport is the loader's view; slave is the environment's view.
interface serving_host_loader_if;

  // Host command stream (host -> loader)
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;

  // Host response stream (loader -> host)
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;

  // Wishbone access into serving memory
  logic [10:0] o_adr;
  logic [31:0] o_dat;
  logic [3:0]  o_sel;
  logic        o_we;
  logic        o_stb;
  logic [31:0] i_rdt;
  logic        i_ack;

  // Memory-mux selects and CPU reset request
  logic        o_sel_wadr;
  logic        o_sel_wdata;
  logic        o_sel_radr;
  logic        o_sel_wen;
  logic        o_sel_rdata;
  logic        o_cpu_rst;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_rdt, i_ack,
    output o_rx_ready, o_tx_data, o_tx_valid,
    output o_adr, o_dat, o_sel, o_we, o_stb,
    output o_sel_wadr, o_sel_wdata, o_sel_radr, o_sel_wen, o_sel_rdata, o_cpu_rst
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_rdt, i_ack,
    input  o_rx_ready, o_tx_data, o_tx_valid,
    input  o_adr, o_dat, o_sel, o_we, o_stb,
    input  o_sel_wadr, o_sel_wdata, o_sel_radr, o_sel_wen, o_sel_rdata, o_cpu_rst
  );

endinterface

// File: rtl/serving_host_loader.sv
// Host-side command bridge for the serving SoC. Decodes framed host bytes
// ('W' write, 'R' read, 'H' hold, 'G' go), performs one full-word Wishbone
// access per W/R frame while the loader owns memory, and streams back a
// status byte or the four read-data bytes (LSB first).
module serving_host_loader #(
  parameter int ACK_TIMEOUT = 64,
  parameter bit RESET_HOLD  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  serving_host_loader_if.master bus
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_HOLD  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;

  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
  localparam logic [7:0] RSP_NOHOLD  = 8'h45;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEE;

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARGS,
    BUS,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_cnt;
  logic        r_we;
  logic        r_hold;
  logic [10:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_resp;
  logic [2:0]  r_respCnt;
  logic [TW-1:0] r_tmo;

  logic        w_rxFire;
  logic        w_txFire;
  logic        w_lastArg;
  logic        w_timeout;
  logic        w_cmdStart;
  logic        w_cmdWrite;
  logic        w_argByte;
  logic        w_holdSet;
  logic        w_holdVal;
  logic        w_loadResp;
  logic [31:0] w_respWord;
  logic [2:0]  w_respCnt;

  assign w_rxFire  = bus.i_rx_valid & bus.o_rx_ready;
  assign w_txFire  = bus.o_tx_valid & bus.i_tx_ready;
  assign w_lastArg = r_we ? (r_cnt == 3'd5) : (r_cnt == 3'd1);
  assign w_timeout = (r_tmo == TMO_LAST);

  // Outputs are decoded from registered state so they cannot glitch
  // combinationally off host or bus inputs.
  assign bus.o_rx_ready  = (r_state == IDLE) || (r_state == ARGS);
  assign bus.o_tx_valid  = (r_state == RESP);
  assign bus.o_tx_data   = r_resp[7:0];
  assign bus.o_stb       = (r_state == BUS);
  assign bus.o_we        = r_we & (r_state == BUS);
  assign bus.o_adr       = r_adr;
  assign bus.o_dat       = r_dat;
  assign bus.o_sel       = 4'b1111;

  assign bus.o_sel_wadr  = r_hold;
  assign bus.o_sel_wdata = r_hold;
  assign bus.o_sel_radr  = r_hold;
  assign bus.o_sel_wen   = r_hold;
  assign bus.o_sel_rdata = ~r_hold;
  assign bus.o_cpu_rst   = r_hold;

  // State register; reset abandons any partial frame or bus cycle at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  always_comb begin
    w_next     = r_state;
    w_cmdStart = 1'b0;
    w_cmdWrite = 1'b0;
    w_argByte  = 1'b0;
    w_holdSet  = 1'b0;
    w_holdVal  = r_hold;
    w_loadResp = 1'b0;
    w_respWord = 32'd0;
    w_respCnt  = 3'd0;

    case (r_state)
      IDLE: begin
        if (w_rxFire) begin
          case (bus.i_rx_data)
            CMD_WRITE: begin
              w_cmdStart = 1'b1;
              w_cmdWrite = 1'b1;
              w_next     = ARGS;
            end
            CMD_READ: begin
              w_cmdStart = 1'b1;
              w_next     = ARGS;
            end
            CMD_HOLD, CMD_GO: begin
              w_holdSet  = 1'b1;
              w_holdVal  = (bus.i_rx_data == CMD_HOLD);
              w_loadResp = 1'b1;
              w_respWord = {24'd0, RSP_OK};
              w_respCnt  = 3'd1;
              w_next     = RESP;
            end
            default: begin
              w_loadResp = 1'b1;
              w_respWord = {24'd0, RSP_UNKNOWN};
              w_respCnt  = 3'd1;
              w_next     = RESP;
            end
          endcase
        end
      end

      ARGS: begin
        if (w_rxFire) begin
          w_argByte = 1'b1;
          if (w_lastArg) begin
            if (!r_hold) begin
              w_loadResp = 1'b1;
              w_respWord = {24'd0, RSP_NOHOLD};
              w_respCnt  = 3'd1;
              w_next     = RESP;
            end else begin
              w_next = BUS;
            end
          end
        end
      end

      BUS: begin
        if (bus.i_ack) begin
          w_loadResp = 1'b1;
          if (r_we) begin
            w_respWord = {24'd0, RSP_OK};
            w_respCnt  = 3'd1;
          end else begin
            w_respWord = bus.i_rdt;
            w_respCnt  = 3'd4;
          end
          w_next = RESP;
        end else if (w_timeout) begin
          w_loadResp = 1'b1;
          w_respWord = {24'd0, RSP_TIMEOUT};
          w_respCnt  = 3'd1;
          w_next     = RESP;
        end
      end

      RESP: begin
        if (w_txFire && (r_respCnt == 3'd1)) begin
          w_next = IDLE;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Frame argument capture: little-endian address then data bytes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 3'd0;
      r_we  <= 1'b0;
      r_adr <= 11'd0;
      r_dat <= 32'd0;
    end else begin
      if (w_cmdStart) begin
        r_cnt <= 3'd0;
        r_we  <= w_cmdWrite;
      end else if (w_argByte) begin
        r_cnt <= r_cnt + 3'd1;
        case (r_cnt)
          3'd0:    r_adr[7:0]   <= bus.i_rx_data;
          3'd1:    r_adr[10:8]  <= bus.i_rx_data[2:0];
          3'd2:    r_dat[7:0]   <= bus.i_rx_data;
          3'd3:    r_dat[15:8]  <= bus.i_rx_data;
          3'd4:    r_dat[23:16] <= bus.i_rx_data;
          3'd5:    r_dat[31:24] <= bus.i_rx_data;
          default: r_cnt        <= r_cnt;
        endcase
      end
    end
  end

  // Memory ownership flag driving the mux selects and CPU reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold <= RESET_HOLD;
    end else if (w_holdSet) begin
      r_hold <= w_holdVal;
    end
  end

  // Ack timeout: counts cycles with o_stb high, cleared whenever idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo <= '0;
    end else if (r_state == BUS) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // Response shifter: low byte is on o_tx_data, shifted out per handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp    <= 32'd0;
      r_respCnt <= 3'd0;
    end else if (w_loadResp) begin
      r_resp    <= w_respWord;
      r_respCnt <= w_respCnt;
    end else if ((r_state == RESP) && w_txFire) begin
      r_resp    <= {8'd0, r_resp[31:8]};
      r_respCnt <= r_respCnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_serving_host_loader.sv
// Directed bench for serving_host_loader: drives host frames, emulates the
// Wishbone slave with a programmable ack delay, collects response bytes and
// compares everything against hand-computed values.
module tb_serving_host_loader;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  serving_host_loader_if busIf ();

  serving_host_loader #(
    .ACK_TIMEOUT(64),
    .RESET_HOLD (1'b1)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (busIf)
  );

  always #5 i_clk = ~i_clk;

  int assertCount = 0;
  int failCount   = 0;

  // Slave model controls and observations
  int          ackDelay   = 1;
  bit          ackEnable  = 1'b1;
  bit          strayAck   = 1'b0;
  bit          monitorOn  = 1'b0;
  bit          expHold    = 1'b1;
  bit          prevStb    = 1'b0;
  int          stbPulses  = 0;
  int          stbCycles  = 0;
  int          stbLen     = 0;
  int          stabErr    = 0;
  int          selErr     = 0;
  int          stbReleased = 0;
  logic [10:0] capAdr = '0;
  logic [31:0] capDat = '0;
  logic        capWe  = 1'b0;
  logic [3:0]  capSel = '0;
  logic [7:0]  txQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Offer one host byte and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    busIf.i_rx_valid = 1'b1;
    busIf.i_rx_data  = b;
    while (!busIf.o_rx_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("rx_ready wait", 32'(busIf.o_rx_ready), 32'd1);
    tick();
    busIf.i_rx_valid = 1'b0;
  endtask

  task automatic sendWrite(input logic [15:0] a, input logic [31:0] d);
    applyStimulus(8'h57);
    applyStimulus(a[7:0]);
    applyStimulus(a[15:8]);
    applyStimulus(d[7:0]);
    applyStimulus(d[15:8]);
    applyStimulus(d[23:16]);
    applyStimulus(d[31:24]);
  endtask

  task automatic sendRead(input logic [15:0] a);
    applyStimulus(8'h52);
    applyStimulus(a[7:0]);
    applyStimulus(a[15:8]);
  endtask

  // Wait for n response bytes and compare them, LSB-first, with expWord.
  task automatic expectResp(input string tag, input int n, input logic [31:0] expWord);
    int guard = 0;
    logic [31:0] got = '0;
    while (txQ.size() < n && guard < 400) begin
      tick();
      guard++;
    end
    checkOutput({tag, " count"}, 32'(txQ.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (txQ.size() > 0) got[8*i +: 8] = txQ.pop_front();
    end
    checkOutput({tag, " bytes"}, got, expWord);
    repeat (2) tick();
  endtask

  // Wishbone slave model, stability/select monitors and response collector.
  always @(negedge i_clk) begin
    if (monitorOn) begin
      if (busIf.o_stb) begin
        if (!prevStb) begin
          stbPulses++;
          stbCycles = 1;
          capAdr = busIf.o_adr;
          capDat = busIf.o_dat;
          capWe  = busIf.o_we;
          capSel = busIf.o_sel;
        end else begin
          stbCycles++;
          if (busIf.o_adr !== capAdr || busIf.o_dat !== capDat ||
              busIf.o_we !== capWe || busIf.o_sel !== capSel) stabErr++;
        end
        stbLen = stbCycles;
        if (!expHold) stbReleased++;
        busIf.i_ack = ackEnable && (stbCycles == ackDelay);
      end else begin
        busIf.i_ack = strayAck;
      end
      prevStb = busIf.o_stb;
      if ({busIf.o_sel_wadr, busIf.o_sel_wdata, busIf.o_sel_radr, busIf.o_sel_wen,
           busIf.o_sel_rdata, busIf.o_cpu_rst} !== (expHold ? 6'b111101 : 6'b000010))
        selErr++;
      if (busIf.o_tx_valid && busIf.i_tx_ready) txQ.push_back(busIf.o_tx_data);
    end
  end

  initial begin
    int guard;
    int holdErr;
    logic [7:0] heldByte;

    busIf.i_rx_valid = 1'b0;
    busIf.i_rx_data  = 8'h00;
    busIf.i_tx_ready = 1'b1;
    busIf.i_ack      = 1'b0;
    busIf.i_rdt      = 32'h0;

    // Reset values
    i_rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset stb/we/txv/rxr",
                32'({busIf.o_stb, busIf.o_we, busIf.o_tx_valid, busIf.o_rx_ready}), 32'b0001);
    checkOutput("reset adr", 32'(busIf.o_adr), 32'h0);
    checkOutput("reset dat", busIf.o_dat, 32'h0);
    checkOutput("reset tx_data", 32'(busIf.o_tx_data), 32'h0);
    checkOutput("reset sel", 32'(busIf.o_sel), 32'hF);
    checkOutput("reset selects",
                32'({busIf.o_sel_wadr, busIf.o_sel_wdata, busIf.o_sel_radr, busIf.o_sel_wen,
                     busIf.o_sel_rdata, busIf.o_cpu_rst}), 32'b111101);
    i_rst = 1'b0;
    monitorOn = 1'b1;
    tick();

    // Write while held
    $display("[TB] write 0x010 <= 0xDEADBEEF");
    ackDelay = 3;
    sendWrite(16'h0010, 32'hDEADBEEF);
    expectResp("write resp", 1, 32'h4B);
    checkOutput("write stb pulses", 32'(stbPulses), 32'd1);
    checkOutput("write adr", 32'(capAdr), 32'h010);
    checkOutput("write dat", capDat, 32'hDEADBEEF);
    checkOutput("write we", 32'(capWe), 32'd1);
    checkOutput("write sel", 32'(capSel), 32'hF);
    checkOutput("write stb length", 32'(stbLen), 32'd3);

    // Read with a 10-cycle ack
    $display("[TB] read 0x010, ack after 10 cycles");
    busIf.i_rdt = 32'hDEADBEEF;
    ackDelay = 10;
    sendRead(16'h0010);
    expectResp("read resp", 4, 32'hDEADBEEF);
    checkOutput("read stb pulses", 32'(stbPulses), 32'd2);
    checkOutput("read we", 32'(capWe), 32'd0);
    checkOutput("read adr", 32'(capAdr), 32'h010);
    checkOutput("read stb length", 32'(stbLen), 32'd10);

    // Release memory, then a read must be refused without bus access
    $display("[TB] G then read while released");
    applyStimulus(8'h47);
    expHold = 1'b0;
    expectResp("G resp", 1, 32'h4B);
    checkOutput("released selects",
                32'({busIf.o_sel_wadr, busIf.o_sel_wdata, busIf.o_sel_radr, busIf.o_sel_wen,
                     busIf.o_sel_rdata, busIf.o_cpu_rst}), 32'b000010);
    sendRead(16'h0000);
    expectResp("released read resp", 1, 32'h45);
    checkOutput("released stb pulses", 32'(stbPulses), 32'd2);

    // Re-hold, then a read that is never acked
    $display("[TB] H then read with no ack");
    applyStimulus(8'h48);
    expHold = 1'b1;
    expectResp("H resp", 1, 32'h4B);
    ackEnable = 1'b0;
    sendRead(16'h0005);
    expectResp("timeout resp", 1, 32'hEE);
    checkOutput("timeout stb length", 32'(stbLen), 32'd64);
    checkOutput("timeout stb pulses", 32'(stbPulses), 32'd3);
    checkOutput("timeout adr", 32'(capAdr), 32'h005);
    strayAck = 1'b1;
    repeat (3) tick();
    strayAck = 1'b0;
    repeat (2) tick();
    checkOutput("stray ack stb pulses", 32'(stbPulses), 32'd3);
    checkOutput("stray ack tx_valid", 32'(busIf.o_tx_valid), 32'd0);
    checkOutput("stray ack tx bytes", 32'(txQ.size()), 32'd0);
    checkOutput("stray ack rx_ready", 32'(busIf.o_rx_ready), 32'd1);
    ackEnable = 1'b1;

    // Unknown command, then reset in the middle of a write frame
    $display("[TB] unknown byte, then reset mid-frame");
    applyStimulus(8'h00);
    expectResp("unknown resp", 1, 32'h3F);
    applyStimulus(8'h47);
    expHold = 1'b0;
    expectResp("G2 resp", 1, 32'h4B);
    applyStimulus(8'h57);
    applyStimulus(8'h10);
    i_rst = 1'b1;
    tick();
    expHold = 1'b1;
    i_rst = 1'b0;
    repeat (10) tick();
    checkOutput("post-reset stb pulses", 32'(stbPulses), 32'd3);
    checkOutput("post-reset tx bytes", 32'(txQ.size()), 32'd0);
    checkOutput("post-reset tx_valid", 32'(busIf.o_tx_valid), 32'd0);
    checkOutput("post-reset rx_ready", 32'(busIf.o_rx_ready), 32'd1);
    checkOutput("post-reset cpu_rst", 32'(busIf.o_cpu_rst), 32'd1);

    // Fresh frame after reset; upper address bits must be dropped
    ackDelay = 1;
    sendWrite(16'hFA34, 32'h44332211);
    expectResp("post-reset write resp", 1, 32'h4B);
    checkOutput("post-reset write pulses", 32'(stbPulses), 32'd4);
    checkOutput("post-reset write adr", 32'(capAdr), 32'h234);
    checkOutput("post-reset write dat", capDat, 32'h44332211);

    // Read response with host back-pressure
    $display("[TB] read with tx_ready held low");
    busIf.i_rdt = 32'h01234567;
    ackDelay = 2;
    busIf.i_tx_ready = 1'b0;
    sendRead(16'h0123);
    guard = 0;
    while (!busIf.o_tx_valid && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("backpressure tx_valid", 32'(busIf.o_tx_valid), 32'd1);
    heldByte = busIf.o_tx_data;
    holdErr = 0;
    repeat (20) begin
      tick();
      if (busIf.o_tx_data !== heldByte || !busIf.o_tx_valid || busIf.o_rx_ready) holdErr++;
    end
    checkOutput("backpressure stability", 32'(holdErr), 32'd0);
    checkOutput("backpressure first byte", 32'(heldByte), 32'h67);
    checkOutput("backpressure no early bytes", 32'(txQ.size()), 32'd0);
    busIf.i_tx_ready = 1'b1;
    expectResp("backpressure resp", 4, 32'h01234567);
    checkOutput("backpressure adr", 32'(capAdr), 32'h123);

    // Whole-run monitors
    checkOutput("bus stable while stb", 32'(stabErr), 32'd0);
    checkOutput("select/cpu_rst tracking", 32'(selErr), 32'd0);
    checkOutput("no stb while released", 32'(stbReleased), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/serving_host_loader.md
Name: serving_host_loader

Overview:
- Host-side command bridge sitting directly upstream of the serving SoC's bridge slave port.
- Accepts a framed byte stream from a host link (UART/JTAG byte FIFO) and issues full-word Wishbone writes and reads into serving memory.
- Drives the five memory-mux selects and holds the CPU in reset while it owns memory.
- Returns status and read data as a byte stream.

Parameters:
- ACK_TIMEOUT, 64, cycles allowed from o_stb rise to i_ack before the transaction is aborted; must be >= 16.
- RESET_HOLD, 1, value of the hold flag after reset: 1 = loader owns memory, CPU held in reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  host command byte
- i_rx_valid  in  1  i_rx_data valid
- o_rx_ready  out  1  byte accepted when i_rx_valid & o_rx_ready
- o_tx_data  out  8  response byte
- o_tx_valid  out  1  response byte valid
- i_tx_ready  in  1  host accepts response byte
- o_adr  out  11  word address [12:2] to SoC bridge port
- o_dat  out  32  write data
- o_sel  out  4  byte select; always 4'b1111
- o_we  out  1  write enable
- o_stb  out  1  strobe
- i_rdt  in  32  read data
- i_ack  in  1  acknowledge
- o_sel_wadr  out  1  mux select, = hold
- o_sel_wdata  out  1  mux select, = hold
- o_sel_radr  out  1  mux select, = hold
- o_sel_wen  out  1  mux select, = hold
- o_sel_rdata  out  1  mux select, = ~hold (0 routes RAM data to bridge)
- o_cpu_rst  out  1  CPU reset request, = hold

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high.
- Reset values:
  - state IDLE, hold = RESET_HOLD
  - o_stb = 0, o_we = 0, o_tx_valid = 0, o_rx_ready = 1
  - o_adr = 0, o_dat = 0, o_tx_data = 0, o_sel = 4'b1111
  - Reset mid-frame or mid-transaction discards everything immediately; o_stb drops the next cycle.
- Commands (first byte):
  - 0x57 'W': 2 address bytes + 4 data bytes, all little-endian.
  - 0x52 'R': 2 address bytes.
  - 0x48 'H': hold := 1.
  - 0x47 'G': hold := 0.
  - Any other byte: respond 0x3F, stay IDLE.
  - Word address = addr16[10:0]; addr16[15:11] ignored.
- State machine:
  - IDLE: accept command byte.
    - H/G update hold in the cycle after acceptance, then RESP 0x4B.
    - W/R: clear byte counter, go to ARGS.
  - ARGS: o_rx_ready = 1; each accepted byte is shifted into the address/data registers; counter increments.
    - After the last byte (2 for R, 6 for W): if hold = 0, go to RESP 0x45 (no bus access); else go to BUS.
  - BUS: o_rx_ready = 0.
    - o_stb = 1 with o_adr/o_dat/o_we stable until i_ack is sampled high.
    - On i_ack: o_stb = 0 the next cycle; reads capture i_rdt.
    - Write then goes to RESP 0x4B; read goes to RESP sending the 4 data bytes, LSB first.
    - Downstream may take up to 10 cycles to ack; no minimum is assumed.
    - Timeout counter starts at o_stb rise. When it reaches ACK_TIMEOUT without i_ack: drop o_stb, RESP 0xEE. A late i_ack is ignored.
  - RESP: o_rx_ready = 0. o_tx_valid = 1 with o_tx_data stable until i_tx_ready. Advance one byte per handshake; after the last byte, o_tx_valid = 0 and return to IDLE the next cycle.
- Hold and mux selects:
  - The hold change takes effect on all select outputs and o_cpu_rst in the same cycle.
  - H while already held or G while released: idempotent, still responds 0x4B.
- Exactly one bus transaction per W/R frame; o_stb is never asserted while hold = 0.
- Back-to-back frames: the next command byte can be accepted in the cycle after returning to IDLE.
- No inter-byte timeout; a partial frame waits indefinitely (recovered only by i_rst).

Test Plan:
- Reset, then send 57 10 00 EF BE AD DE. Required: one o_stb pulse, o_adr = 0x010, o_we = 1, o_dat = 0xDEADBEEF, o_sel = F, held until i_ack; response 4B; o_sel_* = 1, o_sel_rdata = 0, o_cpu_rst = 1 throughout.
- Send 52 10 00 with the bench acking i_rdt = 0xDEADBEEF after 10 cycles. Required: o_we = 0; response EF BE AD DE in order.
- Send 47, then 52 00 00. Required: 4B after G; selects drop to 0, o_sel_rdata = 1, o_cpu_rst = 0; the read gives 45 with no o_stb.
- Send 48 then 52 05 00 with i_ack never asserted. Required: o_stb drops after 64 cycles, response EE; a later stray i_ack produces no effect.
- Send byte 0x00, then assert i_rst mid-frame after 57 10. Required: 3F for the 0x00; after reset, state IDLE, hold = 1, no o_stb, no response.
- Hold i_tx_ready low for 20 cycles during a read response. Required: o_tx_data/o_tx_valid stable, o_rx_ready = 0, no bytes lost.
